// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory.
// Size encodings, FSM states and byte-enable / alignment helpers.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Drops the low address bits a sized access may not use.
    function automatic logic [1:0] align_lo(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic [1:0] a;
        a = lo;
        case (size)
            SZ_HALF: a = {lo[1], 1'b0};
            SZ_WORD: a = 2'b00;
            default: a = lo;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage: byte-enabled synchronous write, combinational read.
// Contents are not reset; word i starts as i for i < 6 in simulation.
module dmem_array #(
    parameter int DEPTH = 128,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [IW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [IW-1:0] raddr,
    output logic [31:0]   rdata
);

    function automatic logic [DEPTH-1:0][31:0] init_mem();
        logic [DEPTH-1:0][31:0] m;
        m = '0;
        for (int i = 0; i < 6 && i < DEPTH; i++) begin
            m[i] = 32'(i);
        end
        return m;
    endfunction

    logic [DEPTH-1:0][31:0] mem = init_mem();

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory: sized loads/stores behind a valid/ready port.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [3:0] WS_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e        state, next;
    logic [3:0]    cnt;
    logic [IW-1:0] lat_idx;
    logic [1:0]    lat_lo, lat_size;
    logic          lat_uns, lat_write, lat_err;

    logic          acc, oor, misal, req_err;
    logic [1:0]    req_lo;
    logic [3:0]    we;
    logic [31:0]   wdata, word, ext;
    logic [IW-1:0] cur_idx;
    logic [1:0]    cur_lo, cur_size;
    logic          cur_uns, cur_write, cur_err;
    logic [7:0]    bsel;
    logic [15:0]   hsel;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign acc       = req_valid && req_ready;
    assign rsp_valid = (state == ST_RESP);

    always_comb begin
        oor    = |req_addr[ADDR_W-1:IW+2];
        req_lo = align_lo(req_size, req_addr[1:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
        misal = ((req_size == SZ_HALF) && req_addr[0]) ||
                ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        misal = 1'b0;
`endif
        req_err = oor || (req_size == 2'd3) || misal;
    end

    // Stores commit on the acceptance edge; lanes are replicated so the
    // byte enables pick the right one.
    always_comb begin
        we = (acc && req_write && !req_err)
           ? byte_en(req_size, req_lo) : 4'b0000;
        case (req_size)
            SZ_BYTE: wdata = {4{req_wdata[7:0]}};
            SZ_HALF: wdata = {2{req_wdata[15:0]}};
            default: wdata = req_wdata;
        endcase
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (req_addr[IW+1:2]),
        .wdata (wdata),
        .raddr (cur_idx),
        .rdata (word)
    );

    // With zero wait states RESP is entered on the acceptance edge,
    // before the latches hold the request.
    always_comb begin
        if (state == ST_IDLE) begin
            cur_idx   = req_addr[IW+1:2];
            cur_lo    = req_lo;
            cur_size  = req_size;
            cur_uns   = req_unsigned;
            cur_write = req_write;
            cur_err   = req_err;
        end else begin
            cur_idx   = lat_idx;
            cur_lo    = lat_lo;
            cur_size  = lat_size;
            cur_uns   = lat_uns;
            cur_write = lat_write;
            cur_err   = lat_err;
        end
        bsel = word[8*cur_lo +: 8];
        hsel = cur_lo[1] ? word[31:16] : word[15:0];
        case (cur_size)
            SZ_BYTE: ext = {{24{!cur_uns && bsel[7]}}, bsel};
            SZ_HALF: ext = {{16{!cur_uns && hsel[15]}}, hsel};
            default: ext = word;
        endcase
    end

    always_comb begin
        next = state;
        unique case (state)
            ST_IDLE: if (acc) next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt == 4'd0) next = ST_RESP;
            ST_RESP: next = ST_IDLE;
            default: next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            lat_idx   <= '0;
            lat_lo    <= 2'b00;
            lat_size  <= 2'b00;
            lat_uns   <= 1'b0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
        end else begin
            state <= next;
            if (acc) begin
                cnt       <= WS_INIT;
                lat_idx   <= req_addr[IW+1:2];
                lat_lo    <= req_lo;
                lat_size  <= req_size;
                lat_uns   <= req_unsigned;
                lat_write <= req_write;
                lat_err   <= req_err;
            end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (next == ST_RESP) begin
                rsp_rdata <= (cur_write || cur_err) ? 32'd0 : ext;
                rsp_err   <= cur_err;
            end
        end
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data memory for the MEMORY (MEM) stage. It replaces the flat word-only array with a byte-addressed, byte-enabled store that supports sized loads and stores: byte, half and word, with sign or zero extension. A valid/ready request port and a configurable wait-state latency let the pipeline model a slower memory and stall on it. It sits between the EX/MEM pipeline register and the MEM/WB write-back path.

## Interface
Parameters:
- ADDR_W, 32: width of the byte address.
- DEPTH, 128: number of 32-bit words in storage; must be a power of two, at least 4.
- WAIT_STATES, 0: extra cycles between request acceptance and the response; range 0..15.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as an error.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; flags a failed access.

## Operation
- State machine IDLE -> WAIT -> RESP -> IDLE.
  - WAIT is skipped when WAIT_STATES = 0.
  - req_ready = 1 only in IDLE and when rst = 0.
- Acceptance: req_valid && req_ready at a rising edge.
  - At acceptance, latch addr, size, unsigned flag and write.
  - A wait counter loads WAIT_STATES-1 and decrements in WAIT.
  - Leave WAIT when the counter reaches 0.
- Store: commits on the acceptance edge, using byte enables derived from size and addr[1:0].
  - Byte lanes are little-endian: byte lane = addr[1:0]; half lane = addr[1].
- Load: read data is captured on the edge entering RESP, so a store followed by a load of the same address returns the new data.
  - The selected lane is shifted to bit 0, then extended per req_unsigned.
- Errors: rsp_err = 1, rsp_rdata = 0, no storage change. An access is an error when:
  - the word index addr[ADDR_W-1:2] >= DEPTH;
  - req_size = 3;
  - it is misaligned (see Configuration).
- Every accepted request, load or store, produces exactly one rsp_valid pulse.
- Storage contents are not cleared by reset. In simulation, word i initialises to i for i < 6 and to 0 otherwise.

## Timing
- Reset values: state IDLE, req_ready 0 while rst is high and 1 from the first cycle after, rsp_valid 0, rsp_rdata 0, rsp_err 0, wait counter 0.
- Latency: rsp_valid rises WAIT_STATES+1 cycles after the acceptance edge and lasts exactly one cycle.
- Throughput: one request per WAIT_STATES+2 cycles.
  - req_ready returns the cycle after RESP, so back-to-back requests are not accepted in RESP.
- rsp_rdata and rsp_err are registered. They hold their value outside the rsp_valid cycle; consumers must qualify them with rsp_valid.
- Request inputs are ignored when req_ready = 0.
- Reset mid-operation: the pending response is dropped (no rsp_valid) and the state returns to IDLE. A store already committed at acceptance stays written.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: the following accesses are errors:
  - a half access with addr[0] = 1;
  - a word access with addr[1:0] != 0.
- Not defined: the offending low address bits are forced to 0 and the access proceeds as aligned, with rsp_err = 0.

## Structure
- Package dmem_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the FSM state enum;
  - a function returning the 4-bit byte-enable mask from size and addr[1:0].
- One sub-module, dmem_array: DEPTH x 32 storage with a 4-bit byte-enable synchronous write and a combinational word read. dmem_ctrl holds the FSM, lane selection and extension.

## Test plan
- Reset, WAIT_STATES=0: load word at 0x8 -> rsp_valid one cycle after acceptance, rdata 0x00000002, err 0; req_ready low during rst.
- Store word 0x80FF7F01 at 0x10, then byte loads at 0x10/0x11/0x13 signed -> 0x00000001, 0x0000007F, 0xFFFFFF80; unsigned 0x13 -> 0x00000080.
- Store half 0xBEEF at 0x22, then load word at 0x20 -> 0xBEEF0000; signed half load at 0x22 -> 0xFFFFBEEF.
- WAIT_STATES=3: load accepted at cycle t -> rsp_valid exactly at t+4; req_ready low at t+1..t+4; a req_valid held throughout is accepted again at t+5.
- Word load at 0x202 with DEPTH=128 -> err=1, rdata=0. Word load at 0x6: trap build -> err=1; non-trap build -> data of 0x4.
- Assert rst in the WAIT cycle of a store -> no rsp_valid; a later load returns the stored value.
